// File: rtl/alu_control_unit_pkg.sv
// alu_cu_pkg: shared types and constants for the ALU control unit slice.
//   - cu_state_t    : sequencer state encoding (FETCH/DECODE/EXEC/WB/HALT)
//   - OP_*          : 5-bit ALU opcode values, OP_HALT stops the sequencer
//   - *_MSB/*_LSB   : instruction word field positions
//   - is_legal_op() : true for opcodes the ALU implements (HALT excluded)
// Optional feature macro used by the slice: ALU_CU_FLAG_REG_EN.
package alu_cu_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_HALT
    } cu_state_t;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00011;
    localparam logic [4:0] OP_OR   = 5'b00100;
    localparam logic [4:0] OP_XOR  = 5'b00101;
    localparam logic [4:0] OP_NOT  = 5'b00110;
    localparam logic [4:0] OP_SLL  = 5'b01000;
    localparam logic [4:0] OP_SRL  = 5'b01001;
    localparam logic [4:0] OP_HALT = 5'b01111;
    localparam logic [4:0] OP_ZERO = 5'b10000;
    localparam logic [4:0] OP_ONES = 5'b11111;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 27;
    localparam int RD_MSB  = 26;
    localparam int RD_LSB  = 22;
    localparam int RA_MSB  = 21;
    localparam int RA_LSB  = 17;
    localparam int RB_MSB  = 16;
    localparam int RB_LSB  = 12;
    localparam int IGN_MSB = 11;

    // The whole upper half of the opcode space (1xxxx) is ALU constant/extended
    // ops, so only the lower half needs an explicit list.
    function automatic logic is_legal_op(input logic [4:0] op);
        if (op[4]) begin
            return 1'b1;
        end
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOT, OP_SLL, OP_SRL: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_control_unit_if.sv
// alu_control_unit_if: bundles the instruction fetch handshake, register file
// ports, ALU opcode/result ports and status outputs of the control unit.
//   master : the control unit (drives instr_ready, pc, rf_*, alu_opcode, status)
//   slave  : the environment (drives instr_valid/instr_data, alu_out/alu_flag)
// With ALU_CU_FLAG_REG_EN defined the bundle also carries status_flag.
interface alu_control_unit_if;
    import alu_cu_pkg::*;

    logic              instr_valid;
    logic [DATA_W-1:0] instr_data;
    logic              instr_ready;
    logic [DATA_W-1:0] pc;
    logic [REG_W-1:0]  rf_ra_addr;
    logic [REG_W-1:0]  rf_rb_addr;
    logic [REG_W-1:0]  alu_opcode;
    logic [DATA_W-1:0] alu_out;
    logic              alu_flag;
    logic              rf_wr_en;
    logic [REG_W-1:0]  rf_wr_addr;
    logic [DATA_W-1:0] rf_wr_data;
    logic              busy;
    logic              halted;
    logic              illegal;

`ifdef ALU_CU_FLAG_REG_EN
    logic              status_flag;

    modport master (
        input  instr_valid, instr_data, alu_out, alu_flag,
        output instr_ready, pc, rf_ra_addr, rf_rb_addr, alu_opcode,
               rf_wr_en, rf_wr_addr, rf_wr_data, busy, halted, illegal, status_flag
    );

    modport slave (
        output instr_valid, instr_data, alu_out, alu_flag,
        input  instr_ready, pc, rf_ra_addr, rf_rb_addr, alu_opcode,
               rf_wr_en, rf_wr_addr, rf_wr_data, busy, halted, illegal, status_flag
    );
`else
    modport master (
        input  instr_valid, instr_data, alu_out, alu_flag,
        output instr_ready, pc, rf_ra_addr, rf_rb_addr, alu_opcode,
               rf_wr_en, rf_wr_addr, rf_wr_data, busy, halted, illegal
    );

    modport slave (
        output instr_valid, instr_data, alu_out, alu_flag,
        input  instr_ready, pc, rf_ra_addr, rf_rb_addr, alu_opcode,
               rf_wr_en, rf_wr_addr, rf_wr_data, busy, halted, illegal
    );
`endif

endinterface

// File: rtl/alu_control_unit_decoder.sv
// alu_cu_decoder: purely combinational split of the instruction register.
//   ir    in  32  latched instruction word
//   op    out 5   opcode field
//   rd    out 5   destination register
//   ra    out 5   source register A
//   rb    out 5   source register B
//   legal out 1   opcode is an implemented ALU op
//   halt  out 1   opcode is HALT
module alu_cu_decoder
    import alu_cu_pkg::*;
(
    input  logic [DATA_W-1:0] ir,
    output logic [REG_W-1:0]  op,
    output logic [REG_W-1:0]  rd,
    output logic [REG_W-1:0]  ra,
    output logic [REG_W-1:0]  rb,
    output logic              legal,
    output logic              halt
);

    logic [IGN_MSB:0] unused_ir_bits;

    assign op    = ir[OP_MSB:OP_LSB];
    assign rd    = ir[RD_MSB:RD_LSB];
    assign ra    = ir[RA_MSB:RA_LSB];
    assign rb    = ir[RB_MSB:RB_LSB];
    assign legal = is_legal_op(op);
    assign halt  = (op == OP_HALT);

    // Low 12 bits carry no meaning in this instruction format.
    assign unused_ir_bits = ir[IGN_MSB:0];

endmodule

// File: rtl/alu_control_unit.sv
// alu_control_unit: multi-cycle sequencer issuing opcodes to the ALU.
//   clk    in  1  system clock, rising edge
//   reset  in  1  synchronous active-high reset
//   bus    master modport of alu_control_unit_if (fetch handshake, pc,
//          register file read/write ports, alu_opcode/alu_out/alu_flag,
//          busy/halted/illegal status)
// Parameters: ALU_WAIT (1..15) cycles the opcode is held in EXEC before
// alu_out is sampled; PC_STEP is added to pc per retired/consumed instruction.
// Macro ALU_CU_FLAG_REG_EN adds status_flag, a copy of alu_flag taken when
// alu_out is sampled; without it alu_flag is ignored.
module alu_control_unit
    import alu_cu_pkg::*;
#(
    parameter int unsigned       ALU_WAIT = 1,
    parameter logic [DATA_W-1:0] PC_STEP  = 32'd1
)(
    input  logic              clk,
    input  logic              reset,
    alu_control_unit_if.master bus
);

    localparam logic [3:0] WAIT_LOAD = 4'(ALU_WAIT - 1);

    cu_state_t         state;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [REG_W-1:0]  opcode_q;
    logic [REG_W-1:0]  wr_addr_q;
    logic [3:0]        wait_cnt;
    logic              ready_q;
    logic              wr_en_q;
    logic              busy_q;
    logic              halted_q;
    logic              illegal_q;

    logic [REG_W-1:0]  dec_op;
    logic [REG_W-1:0]  dec_rd;
    logic [REG_W-1:0]  dec_ra;
    logic [REG_W-1:0]  dec_rb;
    logic              dec_legal;
    logic              dec_halt;

    alu_cu_decoder u_decoder (
        .ir    (ir),
        .op    (dec_op),
        .rd    (dec_rd),
        .ra    (dec_ra),
        .rb    (dec_rb),
        .legal (dec_legal),
        .halt  (dec_halt)
    );

    // Sequencer. Every status output is registered alongside the state change
    // so each output already matches the state it describes in that cycle.
    // rf_wr_en and the pc increment both land on entry to WB, and the ALU
    // result is captured straight into the write-data register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_FETCH;
            ir        <= '0;
            pc_q      <= '0;
            ready_q   <= 1'b0;
            opcode_q  <= OP_ZERO;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wait_cnt  <= '0;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            unique case (state)
                ST_FETCH: begin
                    ready_q <= 1'b1;
                    if (bus.instr_valid && ready_q) begin
                        ir      <= bus.instr_data;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state   <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (dec_halt) begin
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                        state    <= ST_HALT;
                    end else if (!dec_legal) begin
                        illegal_q <= 1'b1;
                        pc_q      <= pc_q + PC_STEP;
                        busy_q    <= 1'b0;
                        ready_q   <= 1'b1;
                        state     <= ST_FETCH;
                    end else begin
                        opcode_q <= dec_op;
                        wait_cnt <= WAIT_LOAD;
                        state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (wait_cnt == 4'd0) begin
                        opcode_q  <= OP_ZERO;
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= dec_rd;
                        wr_data_q <= bus.alu_out;
                        pc_q      <= pc_q + PC_STEP;
                        state     <= ST_WB;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_WB: begin
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= ST_FETCH;
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

`ifdef ALU_CU_FLAG_REG_EN
    logic flag_q;

    // Flag is taken on the same edge as alu_out, so it always belongs to the
    // most recent legal ALU instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            flag_q <= 1'b0;
        end else if (state == ST_EXEC && wait_cnt == 4'd0) begin
            flag_q <= bus.alu_flag;
        end
    end

    assign bus.status_flag = flag_q;
`else
    logic unused_alu_flag;
    assign unused_alu_flag = bus.alu_flag;
`endif

    // Read addresses come straight from the registered IR, so they are valid
    // from the DECODE cycle onward without an extra pipeline stage.
    assign bus.rf_ra_addr  = dec_ra;
    assign bus.rf_rb_addr  = dec_rb;
    assign bus.instr_ready = ready_q;
    assign bus.pc          = pc_q;
    assign bus.alu_opcode  = opcode_q;
    assign bus.rf_wr_en    = wr_en_q;
    assign bus.rf_wr_addr  = wr_addr_q;
    assign bus.rf_wr_data  = wr_data_q;
    assign bus.busy        = busy_q;
    assign bus.halted      = halted_q;
    assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_alu_control_unit.sv
// tb_alu_control_unit: directed checks of alu_control_unit. One instance runs
// with ALU_WAIT=1, a second with ALU_WAIT=4 for hold-time and mid-EXEC reset.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_alu_control_unit;

    logic clk = 1'b0;
    logic reset;
    logic reset4;
    int   checks = 0;
    int   errors = 0;

    alu_control_unit_if bus();
    alu_control_unit_if bus4();

    alu_control_unit #(.ALU_WAIT(1), .PC_STEP(32'd1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    alu_control_unit #(.ALU_WAIT(4), .PC_STEP(32'd1)) dut4 (
        .clk   (clk),
        .reset (reset4),
        .bus   (bus4)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] data, input logic [31:0] result);
        bus.instr_valid = valid;
        bus.instr_data  = data;
        bus.alu_out     = result;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0);
        step();
        step();
        checks++; if (bus.pc !== 32'd0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected %h", bus.pc, 32'd0); end
        checks++; if (bus.instr_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", bus.instr_ready); end
        checks++; if (bus.alu_opcode !== 5'b10000) begin errors++; $display("[TB] FAIL reset_opcode: got %b expected 10000", bus.alu_opcode); end
        checks++; if (bus.rf_wr_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_en: got %b expected 0", bus.rf_wr_en); end
        checks++; if ({bus.rf_wr_addr, bus.rf_ra_addr, bus.rf_rb_addr} !== 15'd0) begin errors++; $display("[TB] FAIL reset_addrs: got %h expected 0", {bus.rf_wr_addr, bus.rf_ra_addr, bus.rf_rb_addr}); end
        checks++; if (bus.rf_wr_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_wr_data: got %h expected 0", bus.rf_wr_data); end
        checks++; if ({bus.busy, bus.halted, bus.illegal} !== 3'b000) begin errors++; $display("[TB] FAIL reset_status: got %b expected 000", {bus.busy, bus.halted, bus.illegal}); end
        reset = 1'b0;
        step();
        checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_ready: got %b expected 1", bus.instr_ready); end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            step();
            checks++; if ({bus.instr_ready, bus.rf_wr_en, bus.busy} !== 3'b100) begin errors++; $display("[TB] FAIL idle_status cycle %0d: got %b expected 100", i, {bus.instr_ready, bus.rf_wr_en, bus.busy}); end
            checks++; if (bus.pc !== 32'd0) begin errors++; $display("[TB] FAIL idle_pc cycle %0d: got %h expected 0", i, bus.pc); end
        end
    endtask

    // 0x00886000: op=00000 rd=2 ra=4 rb=6
    task automatic test_legal();
        applyStimulus(1'b1, 32'h0088_6000, 32'h5);
        bus.alu_flag = 1'b1;
        step();
        applyStimulus(1'b0, 32'h0, 32'h5);
        checks++; if ({bus.rf_ra_addr, bus.rf_rb_addr} !== {5'd4, 5'd6}) begin errors++; $display("[TB] FAIL legal_read_addrs: got %h expected %h", {bus.rf_ra_addr, bus.rf_rb_addr}, {5'd4, 5'd6}); end
        checks++; if ({bus.busy, bus.instr_ready, bus.rf_wr_en} !== 3'b100) begin errors++; $display("[TB] FAIL legal_decode_status: got %b expected 100", {bus.busy, bus.instr_ready, bus.rf_wr_en}); end
        step();
        checks++; if (bus.alu_opcode !== 5'b00000) begin errors++; $display("[TB] FAIL legal_exec_opcode: got %b expected 00000", bus.alu_opcode); end
        checks++; if (bus.rf_wr_en !== 1'b0) begin errors++; $display("[TB] FAIL legal_exec_wr_en: got %b expected 0", bus.rf_wr_en); end
        step();
        applyStimulus(1'b0, 32'h0, 32'hFFFF_0000);
        bus.alu_flag = 1'b0;
        checks++; if (bus.rf_wr_en !== 1'b1) begin errors++; $display("[TB] FAIL legal_wb_wr_en: got %b expected 1", bus.rf_wr_en); end
        checks++; if (bus.rf_wr_addr !== 5'd2) begin errors++; $display("[TB] FAIL legal_wb_addr: got %0d expected 2", bus.rf_wr_addr); end
        checks++; if (bus.rf_wr_data !== 32'h5) begin errors++; $display("[TB] FAIL legal_wb_data: got %h expected 5", bus.rf_wr_data); end
        checks++; if (bus.alu_opcode !== 5'b10000) begin errors++; $display("[TB] FAIL legal_wb_opcode: got %b expected 10000", bus.alu_opcode); end
`ifdef ALU_CU_FLAG_REG_EN
        checks++; if (bus.status_flag !== 1'b1) begin errors++; $display("[TB] FAIL legal_status_flag: got %b expected 1", bus.status_flag); end
`endif
        step();
        checks++; if (bus.pc !== 32'd1) begin errors++; $display("[TB] FAIL legal_pc: got %h expected 1", bus.pc); end
        checks++; if ({bus.rf_wr_en, bus.instr_ready, bus.busy} !== 3'b010) begin errors++; $display("[TB] FAIL legal_back_to_fetch: got %b expected 010", {bus.rf_wr_en, bus.instr_ready, bus.busy}); end
    endtask

    // 0x11400000: op=00010 (illegal) rd=5; 0x19C00000: op=00011 rd=7;
    // 0xF8000000: op=11111 rd=0
    task automatic test_illegal();
        applyStimulus(1'b1, 32'h1140_0000, 32'h1234);
        step();
        applyStimulus(1'b0, 32'h0, 32'h1234);
        step();
        checks++; if (bus.illegal !== 1'b1) begin errors++; $display("[TB] FAIL illegal_flag: got %b expected 1", bus.illegal); end
        checks++; if (bus.pc !== 32'd2) begin errors++; $display("[TB] FAIL illegal_pc: got %h expected 2", bus.pc); end
        checks++; if ({bus.rf_wr_en, bus.instr_ready} !== 2'b01) begin errors++; $display("[TB] FAIL illegal_no_wb: got %b expected 01", {bus.rf_wr_en, bus.instr_ready}); end
        applyStimulus(1'b1, 32'h19C0_0000, 32'hDEAD_BEEF);
        step();
        applyStimulus(1'b0, 32'h0, 32'hDEAD_BEEF);
        step();
        checks++; if (bus.alu_opcode !== 5'b00011) begin errors++; $display("[TB] FAIL after_illegal_opcode: got %b expected 00011", bus.alu_opcode); end
        step();
        checks++; if ({bus.rf_wr_en, bus.rf_wr_addr} !== {1'b1, 5'd7}) begin errors++; $display("[TB] FAIL after_illegal_wb: got %h expected %h", {bus.rf_wr_en, bus.rf_wr_addr}, {1'b1, 5'd7}); end
        checks++; if (bus.rf_wr_data !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL after_illegal_data: got %h expected deadbeef", bus.rf_wr_data); end
        checks++; if ({bus.pc, bus.illegal} !== {32'd3, 1'b1}) begin errors++; $display("[TB] FAIL after_illegal_pc_sticky: got %h expected %h", {bus.pc, bus.illegal}, {32'd3, 1'b1}); end
        step();
        applyStimulus(1'b1, 32'hF800_0000, 32'h0000_0042);
        step();
        applyStimulus(1'b0, 32'h0, 32'h0000_0042);
        step();
        checks++; if (bus.alu_opcode !== 5'b11111) begin errors++; $display("[TB] FAIL ones_opcode: got %b expected 11111", bus.alu_opcode); end
        step();
        checks++; if ({bus.rf_wr_en, bus.rf_wr_addr, bus.rf_wr_data} !== {1'b1, 5'd0, 32'h42}) begin errors++; $display("[TB] FAIL rd0_write: got %h expected %h", {bus.rf_wr_en, bus.rf_wr_addr, bus.rf_wr_data}, {1'b1, 5'd0, 32'h42}); end
        step();
        checks++; if (bus.pc !== 32'd4) begin errors++; $display("[TB] FAIL rd0_pc: got %h expected 4", bus.pc); end
    endtask

    // 0x78000000: op=01111 (HALT); 0x08400000 is a legal SUB offered while halted
    task automatic test_halt();
        applyStimulus(1'b1, 32'h7800_0000, 32'h0);
        step();
        applyStimulus(1'b1, 32'h0840_0000, 32'h99);
        step();
        checks++; if ({bus.halted, bus.instr_ready, bus.busy} !== 3'b100) begin errors++; $display("[TB] FAIL halt_status: got %b expected 100", {bus.halted, bus.instr_ready, bus.busy}); end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if ({bus.halted, bus.instr_ready, bus.rf_wr_en, bus.alu_opcode} !== {3'b100, 5'b10000}) begin errors++; $display("[TB] FAIL halt_hold cycle %0d: got %h expected %h", i, {bus.halted, bus.instr_ready, bus.rf_wr_en, bus.alu_opcode}, {3'b100, 5'b10000}); end
            checks++; if (bus.pc !== 32'd4) begin errors++; $display("[TB] FAIL halt_pc cycle %0d: got %h expected 4", i, bus.pc); end
        end
        applyStimulus(1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if ({bus.pc, bus.halted, bus.illegal} !== {32'd0, 2'b00}) begin errors++; $display("[TB] FAIL halt_reset: got %h expected %h", {bus.pc, bus.halted, bus.illegal}, {32'd0, 2'b00}); end
        step();
        checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("[TB] FAIL halt_reset_ready: got %b expected 1", bus.instr_ready); end
    endtask

    // 0x4A400000: op=01001 rd=9; alu_out changes each EXEC cycle, only the
    // value present in the 4th cycle (0xA4) may be written.
    task automatic test_alu_wait4();
        reset4 = 1'b0;
        step();
        bus4.instr_valid = 1'b1;
        bus4.instr_data  = 32'h4A40_0000;
        step();
        bus4.instr_valid = 1'b0;
        checks++; if (bus4.alu_opcode !== 5'b10000) begin errors++; $display("[TB] FAIL wait4_decode_opcode: got %b expected 10000", bus4.alu_opcode); end
        for (int k = 1; k <= 4; k++) begin
            step();
            bus4.alu_out = 32'hA0 + k;
            checks++; if ({bus4.alu_opcode, bus4.rf_wr_en} !== {5'b01001, 1'b0}) begin errors++; $display("[TB] FAIL wait4_exec cycle %0d: got %h expected %h", k, {bus4.alu_opcode, bus4.rf_wr_en}, {5'b01001, 1'b0}); end
        end
        step();
        bus4.alu_out = 32'h0;
        checks++; if ({bus4.rf_wr_en, bus4.rf_wr_addr} !== {1'b1, 5'd9}) begin errors++; $display("[TB] FAIL wait4_wb: got %h expected %h", {bus4.rf_wr_en, bus4.rf_wr_addr}, {1'b1, 5'd9}); end
        checks++; if (bus4.rf_wr_data !== 32'hA4) begin errors++; $display("[TB] FAIL wait4_data: got %h expected a4", bus4.rf_wr_data); end
        checks++; if ({bus4.alu_opcode, bus4.pc} !== {5'b10000, 32'd1}) begin errors++; $display("[TB] FAIL wait4_opcode_pc: got %h expected %h", {bus4.alu_opcode, bus4.pc}, {5'b10000, 32'd1}); end
        step();
    endtask

    // 0x20800000: op=00100 rd=2; reset lands in the 2nd of 4 EXEC cycles
    task automatic test_reset_mid_exec();
        bus4.instr_valid = 1'b1;
        bus4.instr_data  = 32'h2080_0000;
        bus4.alu_out     = 32'h77;
        step();
        bus4.instr_valid = 1'b0;
        step();
        step();
        checks++; if (bus4.alu_opcode !== 5'b00100) begin errors++; $display("[TB] FAIL midexec_opcode: got %b expected 00100", bus4.alu_opcode); end
        reset4 = 1'b1;
        step();
        reset4 = 1'b0;
        checks++; if ({bus4.alu_opcode, bus4.rf_wr_en, bus4.busy} !== {5'b10000, 2'b00}) begin errors++; $display("[TB] FAIL midexec_reset: got %h expected %h", {bus4.alu_opcode, bus4.rf_wr_en, bus4.busy}, {5'b10000, 2'b00}); end
        checks++; if (bus4.pc !== 32'd0) begin errors++; $display("[TB] FAIL midexec_pc: got %h expected 0", bus4.pc); end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if ({bus4.rf_wr_en, bus4.instr_ready, bus4.pc} !== {2'b01, 32'd0}) begin errors++; $display("[TB] FAIL midexec_after cycle %0d: got %h expected %h", i, {bus4.rf_wr_en, bus4.instr_ready, bus4.pc}, {2'b01, 32'd0}); end
        end
    endtask

    initial begin
        reset4           = 1'b1;
        bus.alu_flag     = 1'b0;
        bus4.instr_valid = 1'b0;
        bus4.instr_data  = 32'h0;
        bus4.alu_out     = 32'h0;
        bus4.alu_flag    = 1'b0;
        @(negedge clk);
        test_reset();
        test_idle();
        test_legal();
        test_illegal();
        test_halt();
        test_alu_wait4();
        test_reset_mid_exec();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
